escalonador_contexto: RTL and testbench

OS-side counterpart of the program counter's preemption logic. It receives each preemption event (`flag_faz_preempcao`) and the interrupted address (`salva_PC`), and saves that address into a per-process context table. On OS request it picks the next runnable process round-robin and returns its resume address and program id (`jump_prog`) to the PC. It sits between the PC and the OS instruction path and holds all user-process resume state.

---
 rtl/escalonador_pkg.sv | 27 ++
 rtl/contexto_tabela.sv | 66 ++++++
 rtl/escalonador_contexto.sv | 176 +++++++++++++++++
 tb/tb_escalonador_contexto.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_pkg.sv
// rtl/escalonador_pkg.sv - shared types and constants for the context scheduler
// Contents:
//   estado_t      scheduler state (OS, SAVE, SELECT, DISPATCH, RUN)
//   JP_SO         jump_prog code meaning "OS is running"
//   OS_ENTRY      OS entry address, shared with the PC's OS return line
//   PC_W_DEFAULT  default address width
//   proximo_slot  round-robin successor of a slot id, wrapping n -> 1
package escalonador_pkg;

  typedef enum logic [2:0] {
    ST_OS,
    ST_SAVE,
    ST_SELECT,
    ST_DISPATCH,
    ST_RUN
  } estado_t;

  localparam logic [1:0] JP_SO        = 2'd0;
  localparam int         OS_ENTRY     = 3;
  localparam int         PC_W_DEFAULT = 32;

  // Slot ids run 1..n; the successor of n is 1.
  function automatic logic [1:0] proximo_slot(input logic [1:0] s, input logic [1:0] n);
    return (s >= n) ? 2'd1 : s + 2'd1;
  endfunction

endpackage

// File: rtl/contexto_tabela.sv
// rtl/contexto_tabela.sv - per-process context table (valid bit plus resume PC)
// Ports:
//   clock, reset_geral_n          clock, synchronous active-low reset
//   save_en/save_id/save_pc       write port for a preempted process's PC
//   load_en/load_id/load_pc       write port for proc_load (sets valid)
//   clr_en/clr_id                 clears the valid bit of a finished process
//   rd_id -> rd_valid/rd_pc       combinational read of one slot
// Slot ids are 1..NUM_PROC; any other id matches no slot.
module contexto_tabela #(
  parameter int NUM_PROC = 3,
  parameter int PC_W     = 32
) (
  input  logic            clock,
  input  logic            reset_geral_n,
  input  logic            save_en,
  input  logic [1:0]      save_id,
  input  logic [PC_W-1:0] save_pc,
  input  logic            load_en,
  input  logic [1:0]      load_id,
  input  logic [PC_W-1:0] load_pc,
  input  logic            clr_en,
  input  logic [1:0]      clr_id,
  input  logic [1:0]      rd_id,
  output logic            rd_valid,
  output logic [PC_W-1:0] rd_pc
);

  logic            valid_q [NUM_PROC];
  logic [PC_W-1:0] ctx_q   [NUM_PROC];

  // The controller never aims save/clear and load at the same slot in one
  // cycle, so the write order below is only a tie-break for safety.
  always_ff @(posedge clock) begin
    if (!reset_geral_n) begin
      for (int s = 0; s < NUM_PROC; s++) begin
        valid_q[s] <= 1'b0;
        ctx_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_PROC; s++) begin
        if (clr_en && clr_id == 2'(s + 1)) begin
          valid_q[s] <= 1'b0;
        end
        if (save_en && save_id == 2'(s + 1)) begin
          ctx_q[s] <= save_pc;
        end
        if (load_en && load_id == 2'(s + 1)) begin
          valid_q[s] <= 1'b1;
          ctx_q[s]   <= load_pc;
        end
      end
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_pc    = '0;
    for (int s = 0; s < NUM_PROC; s++) begin
      if (rd_id == 2'(s + 1)) begin
        rd_valid = valid_q[s];
        rd_pc    = ctx_q[s];
      end
    end
  end

endmodule

// File: rtl/escalonador_contexto.sv
// rtl/escalonador_contexto.sv - round-robin context scheduler between PC and OS
// Ports:
//   clock, reset_geral_n              clock, synchronous active-low reset
//   flag_faz_preempcao, salva_PC      preemption event and interrupted PC
//   proc_load/_id, proc_start_pc      register or overwrite a process slot
//   proc_finish                       running process terminated
//   sched_req                         OS asks for the next dispatch
//   resume_valid, resume_pc           one-cycle dispatch pulse and its address
//   jump_prog                         running program (0 = OS, else slot id)
//   no_ready, load_err                one-cycle status pulses
//   busy                              high in SAVE/SELECT/DISPATCH
module escalonador_contexto
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC = 3,
  parameter int PC_W     = PC_W_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_geral_n,
  input  logic            flag_faz_preempcao,
  input  logic [PC_W-1:0] salva_PC,
  input  logic            proc_load,
  input  logic [1:0]      proc_load_id,
  input  logic [PC_W-1:0] proc_start_pc,
  input  logic            proc_finish,
  input  logic            sched_req,
  output logic            resume_valid,
  output logic [PC_W-1:0] resume_pc,
  output logic [1:0]      jump_prog,
  output logic            no_ready,
  output logic            load_err,
  output logic            busy
);

  localparam logic [1:0] NP = 2'(NUM_PROC);

  estado_t         state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      scan_q, scan_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      jp_q, jp_d;
  logic [PC_W-1:0] hold_q, hold_d;
  logic [PC_W-1:0] rpc_q, rpc_d;
  logic            no_ready_q, no_ready_d;
  logic            load_err_q, load_err_d;

  logic            save_en, clr_en, load_ok, load_bad;
  logic            rd_valid;
  logic [PC_W-1:0] rd_pc;

  // The slot owning the live context (RUN, or SAVE writing it back) must not
  // be overwritten underneath it.
  assign load_bad = (proc_load_id == 2'd0) || (proc_load_id > NP) ||
                    (((state_q == ST_RUN) || (state_q == ST_SAVE)) && (proc_load_id == cur_q));
  assign load_ok  = proc_load && !load_bad;

  contexto_tabela #(
    .NUM_PROC (NUM_PROC),
    .PC_W     (PC_W)
  ) u_tabela (
    .clock         (clock),
    .reset_geral_n (reset_geral_n),
    .save_en       (save_en),
    .save_id       (cur_q),
    .save_pc       (hold_q),
    .load_en       (load_ok),
    .load_id       (proc_load_id),
    .load_pc       (proc_start_pc),
    .clr_en        (clr_en),
    .clr_id        (cur_q),
    .rd_id         (scan_q),
    .rd_valid      (rd_valid),
    .rd_pc         (rd_pc)
  );

  always_ff @(posedge clock) begin
    if (!reset_geral_n) begin
      state_q    <= ST_OS;
      rr_q       <= NP;
      cur_q      <= 2'd0;
      scan_q     <= 2'd1;
      cnt_q      <= 2'd0;
      jp_q       <= JP_SO;
      hold_q     <= '0;
      rpc_q      <= '0;
      no_ready_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cur_q      <= cur_d;
      scan_q     <= scan_d;
      cnt_q      <= cnt_d;
      jp_q       <= jp_d;
      hold_q     <= hold_d;
      rpc_q      <= rpc_d;
      no_ready_q <= no_ready_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cur_d        = cur_q;
    scan_d       = scan_q;
    cnt_d        = cnt_q;
    jp_d         = jp_q;
    hold_d       = hold_q;
    rpc_d        = rpc_q;
    no_ready_d   = 1'b0;
    load_err_d   = proc_load && load_bad;
    save_en      = 1'b0;
    clr_en       = 1'b0;
    resume_valid = 1'b0;

    case (state_q)
      ST_OS: begin
        if (sched_req) begin
          state_d = ST_SELECT;
          scan_d  = proximo_slot(rr_q, NP);
          cnt_d   = 2'd0;
        end
      end
      ST_SELECT: begin
        // cnt_q counts slots already rejected; the NUM_PROC-th miss gives up.
        if (rd_valid) begin
          cur_d   = scan_q;
          rpc_d   = rd_pc;
          state_d = ST_DISPATCH;
        end else if (cnt_q == NP - 2'd1) begin
          no_ready_d = 1'b1;
          state_d    = ST_OS;
        end else begin
          scan_d = proximo_slot(scan_q, NP);
          cnt_d  = cnt_q + 2'd1;
        end
      end
      ST_DISPATCH: begin
        resume_valid = 1'b1;
        rr_d         = cur_q;
        jp_d         = cur_q;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        // Termination wins over a simultaneous preemption: nothing to save.
        if (proc_finish) begin
          clr_en  = 1'b1;
          jp_d    = JP_SO;
          cur_d   = 2'd0;
          state_d = ST_OS;
        end else if (flag_faz_preempcao) begin
          hold_d  = salva_PC;
          jp_d    = JP_SO;
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        save_en = 1'b1;
        cur_d   = 2'd0;
        state_d = ST_OS;
      end
      default: begin
        state_d = ST_OS;
      end
    endcase
  end

  assign resume_pc = rpc_q;
  assign jump_prog = jp_q;
  assign no_ready  = no_ready_q;
  assign load_err  = load_err_q;
  assign busy      = (state_q == ST_SAVE) || (state_q == ST_SELECT) || (state_q == ST_DISPATCH);

endmodule

// File: tb/tb_escalonador_contexto.sv
// tb/tb_escalonador_contexto.sv - self-checking bench for escalonador_contexto
module tb_escalonador_contexto;

  localparam int NP = 3;

  logic        clock = 1'b0;
  logic        reset_geral_n;
  logic        flag_faz_preempcao;
  logic [31:0] salva_PC;
  logic        proc_load;
  logic [1:0]  proc_load_id;
  logic [31:0] proc_start_pc;
  logic        proc_finish;
  logic        sched_req;

  logic        resume_valid, no_ready, load_err, busy;
  logic [31:0] resume_pc;
  logic [1:0]  jump_prog;

  logic        resume_valid_2, no_ready_2, load_err_2, busy_2;
  logic [31:0] resume_pc_2;
  logic [1:0]  jump_prog_2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot table, last dispatched slot, running slot (0 = OS).
  bit          mvalid [1:NP];
  logic [31:0] mctx   [1:NP];
  int          mrr;
  int          mcur;

  always #5 clock = ~clock;

  escalonador_contexto #(.NUM_PROC(NP), .PC_W(32)) u_dut (
    .clock              (clock),
    .reset_geral_n      (reset_geral_n),
    .flag_faz_preempcao (flag_faz_preempcao),
    .salva_PC           (salva_PC),
    .proc_load          (proc_load),
    .proc_load_id       (proc_load_id),
    .proc_start_pc      (proc_start_pc),
    .proc_finish        (proc_finish),
    .sched_req          (sched_req),
    .resume_valid       (resume_valid),
    .resume_pc          (resume_pc),
    .jump_prog          (jump_prog),
    .no_ready           (no_ready),
    .load_err           (load_err),
    .busy               (busy)
  );

  escalonador_contexto #(.NUM_PROC(2), .PC_W(32)) u_dut2 (
    .clock              (clock),
    .reset_geral_n      (reset_geral_n),
    .flag_faz_preempcao (flag_faz_preempcao),
    .salva_PC           (salva_PC),
    .proc_load          (proc_load),
    .proc_load_id       (proc_load_id),
    .proc_start_pc      (proc_start_pc),
    .proc_finish        (proc_finish),
    .sched_req          (sched_req),
    .resume_valid       (resume_valid_2),
    .resume_pc          (resume_pc_2),
    .jump_prog          (jump_prog_2),
    .no_ready           (no_ready_2),
    .load_err           (load_err_2),
    .busy               (busy_2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    for (int s = 1; s <= NP; s++) begin
      mvalid[s] = 1'b0;
      mctx[s]   = 32'd0;
    end
    mrr  = NP;
    mcur = 0;
  endtask

  task automatic ld(input int id, input logic [31:0] pc, input bit chk2, input bit exp2);
    bit bad;
    bad = (id == 0) || (id > NP) || (mcur != 0 && id == mcur);
    proc_load     = 1'b1;
    proc_load_id  = 2'(id);
    proc_start_pc = pc;
    step;
    proc_load = 1'b0;
    check_eq("load_err", 32'(load_err), 32'(bad));
    if (chk2) check_eq("load_err_np2", 32'(load_err_2), 32'(exp2));
    if (!bad) begin
      mvalid[id] = 1'b1;
      mctx[id]   = pc;
    end else begin
      step;
      check_eq("load_err_pulse", 32'(load_err), 32'd0);
    end
  endtask

  task automatic sched;
    int  k, sel, s, n;
    bit  found;
    k = 0; sel = 0; s = mrr; found = 1'b0;
    for (int i = 1; i <= NP; i++) begin
      s = (s % NP) + 1;
      if (!found && mvalid[s]) begin
        found = 1'b1;
        k     = i;
        sel   = s;
      end
    end
    n = found ? k : NP;
    sched_req = 1'b1;
    step;
    sched_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_eq("busy_select", 32'(busy), 32'd1);
      check_eq("rv_early", 32'(resume_valid), 32'd0);
      step;
    end
    if (found) begin
      check_eq("resume_valid", 32'(resume_valid), 32'd1);
      check_eq("resume_pc", resume_pc, mctx[sel]);
      check_eq("jp_dispatch", 32'(jump_prog), 32'd0);
      step;
      check_eq("jp_run", 32'(jump_prog), 32'(sel));
      check_eq("rv_after", 32'(resume_valid), 32'd0);
      check_eq("busy_run", 32'(busy), 32'd0);
      mrr  = sel;
      mcur = sel;
    end else begin
      check_eq("no_ready", 32'(no_ready), 32'd1);
      check_eq("rv_empty", 32'(resume_valid), 32'd0);
      check_eq("jp_empty", 32'(jump_prog), 32'd0);
      step;
      check_eq("no_ready_pulse", 32'(no_ready), 32'd0);
      check_eq("busy_empty", 32'(busy), 32'd0);
    end
  endtask

  task automatic preempt(input logic [31:0] pc, input bit do_load, input int lid, input logic [31:0] lpc);
    bit bad;
    flag_faz_preempcao = 1'b1;
    salva_PC           = pc;
    step;
    flag_faz_preempcao = 1'b0;
    salva_PC           = $urandom;
    check_eq("jp_preempt", 32'(jump_prog), 32'd0);
    check_eq("busy_save", 32'(busy), 32'd1);
    if (do_load) begin
      bad = (lid == 0) || (lid > NP) || (lid == mcur);
      proc_load     = 1'b1;
      proc_load_id  = 2'(lid);
      proc_start_pc = lpc;
      step;
      proc_load = 1'b0;
      check_eq("load_err_save", 32'(load_err), 32'(bad));
      if (!bad) begin
        mvalid[lid] = 1'b1;
        mctx[lid]   = lpc;
      end
    end else begin
      step;
    end
    check_eq("busy_after_save", 32'(busy), 32'd0);
    mctx[mcur] = pc;
    mcur       = 0;
  endtask

  task automatic finish(input bit with_flag);
    proc_finish        = 1'b1;
    flag_faz_preempcao = with_flag;
    salva_PC           = $urandom;
    step;
    proc_finish        = 1'b0;
    flag_faz_preempcao = 1'b0;
    check_eq("jp_finish", 32'(jump_prog), 32'd0);
    check_eq("busy_finish", 32'(busy), 32'd0);
    mvalid[mcur] = 1'b0;
    mcur         = 0;
  endtask

  task automatic noise;
    flag_faz_preempcao = 1'b1;
    proc_finish        = 1'($urandom);
    salva_PC           = $urandom;
    step;
    flag_faz_preempcao = 1'b0;
    proc_finish        = 1'b0;
    check_eq("jp_os_noise", 32'(jump_prog), 32'd0);
    check_eq("busy_os_noise", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_geral_n      = 1'b0;
    flag_faz_preempcao = 1'b0;
    salva_PC           = 32'd0;
    proc_load          = 1'b0;
    proc_load_id       = 2'd0;
    proc_start_pc      = 32'd0;
    proc_finish        = 1'b0;
    sched_req          = 1'b0;
    step;
    step;
    check_eq("rst_jp", 32'(jump_prog), 32'd0);
    check_eq("rst_rpc", resume_pc, 32'd0);
    check_eq("rst_rv", 32'(resume_valid), 32'd0);
    check_eq("rst_nr", 32'(no_ready), 32'd0);
    check_eq("rst_le", 32'(load_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset_geral_n = 1'b1;
    model_reset();

    noise();
    ld(1, 32'd10, 1'b0, 1'b0);
    ld(2, 32'd20, 1'b0, 1'b0);
    sched();
    preempt(32'h2A, 1'b0, 0, 32'd0);
    sched();
    preempt(32'h55, 1'b0, 0, 32'd0);
    sched();
    preempt(32'h60, 1'b0, 0, 32'd0);
    sched();
    finish(1'b1);
    sched();
    finish(1'b0);
    sched();

    ld(0, 32'h77, 1'b1, 1'b1);
    ld(3, 32'h33, 1'b1, 1'b1);
    sched();
    ld(3, 32'h99, 1'b0, 1'b0);
    ld(1, 32'h11, 1'b0, 1'b0);
    preempt(32'h70, 1'b1, 2, 32'h22);
    sched();
    preempt(32'h80, 1'b0, 0, 32'd0);

    sched_req = 1'b1;
    step;
    sched_req     = 1'b0;
    reset_geral_n = 1'b0;
    step;
    reset_geral_n = 1'b1;
    check_eq("midrst_jp", 32'(jump_prog), 32'd0);
    check_eq("midrst_rpc", resume_pc, 32'd0);
    check_eq("midrst_rv", 32'(resume_valid), 32'd0);
    check_eq("midrst_nr", 32'(no_ready), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    sched();

    for (int it = 0; it < 120; it++) begin
      int r;
      if (mcur == 0) begin
        r = $urandom_range(0, 3);
        case (r)
          0, 1:    ld($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
          2:       sched();
          default: noise();
        endcase
      end else begin
        r = $urandom_range(0, 4);
        case (r)
          0:       preempt($urandom, 1'b0, 0, 32'd0);
          1:       preempt($urandom, 1'b1, $urandom_range(0, 3), $urandom);
          2:       finish(1'($urandom));
          3:       ld($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
          default: ld(mcur, $urandom, 1'b0, 1'b0);
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
